// File: rtl/atm_pkg.sv
// Shared definitions for the ATM front-panel controller.
//   panel_state_e : panel FSM state encoding
//   KEY_*         : keypad codes (0-9 are digits, F is unused)
//   TXN_TYPE*     : encoding of the txn_type output
package atm_pkg;

    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_CARD   = 3'd1,
        P_PIN    = 3'd2,
        P_SELECT = 3'd3,
        P_WAIT   = 3'd4,
        P_EJECT  = 3'd5
    } panel_state_e;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_TXN0   = 4'hC;
    localparam logic [3:0] KEY_TXN1   = 4'hD;
    localparam logic [3:0] KEY_TXN2   = 4'hE;

    localparam logic [1:0] TXN_TYPE0 = 2'd0;
    localparam logic [1:0] TXN_TYPE1 = 2'd1;
    localparam logic [1:0] TXN_TYPE2 = 2'd2;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // States in which a card is inserted and a session result is still owed.
    function automatic logic in_session(input panel_state_e s);
        return s inside {P_CARD, P_PIN, P_SELECT, P_WAIT};
    endfunction

endpackage

// File: rtl/atm_pin_buffer.sv
// PIN entry buffer: shifts BCD digits in (first digit ends up most significant),
// counts them saturating at PIN_DIGITS and flags an exact match against pin_ref.
//   clk, reset_n  : clock, async active-low reset
//   clr           : empty the buffer (wins over digit_valid)
//   digit_valid   : shift digit in (dropped once the buffer is full)
//   digit         : BCD digit
//   pin_ref       : reference PIN, most significant digit first
//   match         : full count and buffer equals pin_ref
// PIN_DIGITS must be at least 2.
module atm_pin_buffer #(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    output logic                    match
);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PIN_DIGITS);

    logic [4*PIN_DIGITS-1:0] pin_buf_q, pin_buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        pin_buf_d = pin_buf_q;
        cnt_d     = cnt_q;
        if (clr) begin
            pin_buf_d = '0;
            cnt_d     = '0;
        end else if (digit_valid && (cnt_q != FULL)) begin
            pin_buf_d = {pin_buf_q[4*PIN_DIGITS-5:0], digit};
            cnt_d     = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_buf_q <= '0;
            cnt_q     <= '0;
        end else begin
            pin_buf_q <= pin_buf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign match = (cnt_q == FULL) && (pin_buf_q == pin_ref);

endmodule

// File: rtl/atm_panel_ctrl.sv
// ATM front-panel controller. Turns card-sense and keypad strobes into the core's
// held levels (card_insert, pin_enter, txn_select) and a txn_confirm pulse, checks
// the PIN with a retry limit, enforces inactivity/response timeouts and reports
// one result pulse per session. All outputs are registered.
//   clk, reset_n                 : clock, async active-low reset
//   card_sense                   : card present (synchronised level)
//   key_valid, key_code          : keypad strobe and code
//   pin_ref                      : reference PIN, BCD, MSD first
//   txn_complete, txn_failed     : core result
//   card_insert, pin_enter,
//   txn_select, txn_type         : levels to the core
//   txn_confirm                  : 1-cycle confirm pulse to the core
//   pin_error, result_ok,
//   result_fail                  : 1-cycle status pulses
//   busy                         : not idle
module atm_panel_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int MAX_TRIES    = 3,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int RESP_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    card_sense,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    input  logic                    txn_complete,
    input  logic                    txn_failed,
    output logic                    card_insert,
    output logic                    pin_enter,
    output logic                    txn_select,
    output logic                    txn_confirm,
    output logic [1:0]              txn_type,
    output logic                    pin_error,
    output logic                    result_ok,
    output logic                    result_fail,
    output logic                    busy
);
    localparam int MAX_TMO = (IDLE_TIMEOUT > RESP_TIMEOUT) ? IDLE_TIMEOUT : RESP_TIMEOUT;
    localparam int TMR_W   = $clog2(MAX_TMO);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TMR_W-1:0] IDLE_LOAD = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RESP_LOAD = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);

    panel_state_e state_q, state_d;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [1:0]       txn_type_q, txn_type_d;
    logic card_insert_q, card_insert_d, pin_enter_q, pin_enter_d;
    logic txn_select_q, txn_select_d, txn_confirm_q, txn_confirm_d;
    logic pin_error_q, pin_error_d, result_ok_q, result_ok_d;
    logic result_fail_q, result_fail_d, busy_q, busy_d;

    logic key_enter, key_cancel, key_txn, key_digit;
    logic removed, idle_exp, tmr_zero, pin_match, pb_clr, pb_digit;

    assign key_enter  = key_valid && (key_code == KEY_ENTER);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);
    assign key_txn    = key_valid && (key_code inside {KEY_TXN0, KEY_TXN1, KEY_TXN2});
    assign key_digit  = key_valid && is_digit(key_code);
    // Card pulled mid-session outranks anything else seen in the same cycle.
    assign removed    = in_session(state_q) && !card_sense;
    assign tmr_zero   = (tmr_q == '0);
    // A key in the expiry cycle counts as activity, not as a timeout.
    assign idle_exp   = !key_valid && tmr_zero;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= P_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE:   if (card_sense) state_d = P_CARD;
            P_CARD: begin
                if (removed)         state_d = P_IDLE;
                else if (key_cancel) state_d = P_EJECT;
                else if (key_enter) begin
                    if (pin_match)               state_d = P_PIN;
                    else if (tries_q == TRY_LAST) state_d = P_EJECT;
                end
                else if (idle_exp)   state_d = P_EJECT;
            end
            P_PIN: begin
                if (removed)         state_d = P_IDLE;
                else if (key_cancel) state_d = P_EJECT;
                else if (key_txn)    state_d = P_SELECT;
                else if (idle_exp)   state_d = P_EJECT;
            end
            P_SELECT: begin
                if (removed)         state_d = P_IDLE;
                else if (key_cancel) state_d = P_EJECT;
                else if (key_enter)  state_d = P_WAIT;
                else if (idle_exp)   state_d = P_EJECT;
            end
            P_WAIT: begin
                if (removed) state_d = P_IDLE;
                else if (txn_complete || txn_failed || tmr_zero) state_d = P_EJECT;
            end
            P_EJECT:  if (!card_sense) state_d = P_IDLE;
            default:  state_d = P_IDLE;
        endcase
    end

    // ---------------- outputs (registered next cycle) ----------------
    always_comb begin
        txn_confirm_d = (state_q == P_SELECT) && (state_d == P_WAIT);
        // Levels follow the next state, but stay up through the confirm cycle.
        card_insert_d = (state_d inside {P_CARD, P_PIN, P_SELECT}) || txn_confirm_d;
        pin_enter_d   = (state_d inside {P_PIN, P_SELECT}) || txn_confirm_d;
        txn_select_d  = (state_d == P_SELECT) || txn_confirm_d;
        pin_error_d   = (state_q == P_CARD) && !removed && key_enter && !pin_match;
        result_ok_d   = (state_q == P_WAIT) && (state_d == P_EJECT) &&
                        txn_complete && !txn_failed;
        // Every way out of a session that is not a success is a failure.
        result_fail_d = in_session(state_q) && (state_d inside {P_IDLE, P_EJECT}) &&
                        !result_ok_d;
        busy_d        = (state_d != P_IDLE);
        txn_type_d    = txn_type_q;
        if ((state_q == P_PIN) && (state_d == P_SELECT)) begin
            case (key_code)
                KEY_TXN0: txn_type_d = TXN_TYPE0;
                KEY_TXN1: txn_type_d = TXN_TYPE1;
                KEY_TXN2: txn_type_d = TXN_TYPE2;
                default:  txn_type_d = txn_type_q;
            endcase
        end
    end

    // ---------------- timers, tries, PIN buffer control ----------------
    // One down-counter serves as the inactivity timer in CARD/PIN/SELECT and as
    // the response timer in WAIT; the two uses never overlap.
    always_comb begin
        tmr_d   = tmr_q;
        tries_d = tries_q;
        case (state_q)
            P_IDLE: tmr_d = IDLE_LOAD;
            P_CARD, P_PIN, P_SELECT: begin
                if (state_d == P_WAIT)  tmr_d = RESP_LOAD;
                else if (key_valid)     tmr_d = IDLE_LOAD;
                else if (!tmr_zero)     tmr_d = tmr_q - 1'b1;
            end
            P_WAIT: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
            default: tmr_d = tmr_q;
        endcase
        if (state_q == P_IDLE) tries_d = '0;
        else if (pin_error_d)  tries_d = tries_q + 1'b1;
    end

    assign pb_clr   = (state_q == P_IDLE) || pin_error_d;
    assign pb_digit = (state_q == P_CARD) && !removed && key_digit;

    atm_pin_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_pin_buffer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (pb_clr),
        .digit_valid (pb_digit),
        .digit       (key_code),
        .pin_ref     (pin_ref),
        .match       (pin_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q         <= '0;
            tries_q       <= '0;
            txn_type_q    <= '0;
            card_insert_q <= 1'b0;
            pin_enter_q   <= 1'b0;
            txn_select_q  <= 1'b0;
            txn_confirm_q <= 1'b0;
            pin_error_q   <= 1'b0;
            result_ok_q   <= 1'b0;
            result_fail_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            tries_q       <= tries_d;
            txn_type_q    <= txn_type_d;
            card_insert_q <= card_insert_d;
            pin_enter_q   <= pin_enter_d;
            txn_select_q  <= txn_select_d;
            txn_confirm_q <= txn_confirm_d;
            pin_error_q   <= pin_error_d;
            result_ok_q   <= result_ok_d;
            result_fail_q <= result_fail_d;
            busy_q        <= busy_d;
        end
    end

    assign card_insert = card_insert_q;
    assign pin_enter   = pin_enter_q;
    assign txn_select  = txn_select_q;
    assign txn_confirm = txn_confirm_q;
    assign txn_type    = txn_type_q;
    assign pin_error   = pin_error_q;
    assign result_ok   = result_ok_q;
    assign result_fail = result_fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_atm_panel_ctrl.sv
// Self-checking bench for atm_panel_ctrl: scenario tasks with randomized PINs,
// transaction types and response delays, plus a queue-based PIN entry model.
module tb_atm_panel_ctrl;
    localparam int PIN_DIGITS   = 4;
    localparam int MAX_TRIES    = 3;
    localparam int IDLE_TIMEOUT = 1024;
    localparam int RESP_TIMEOUT = 256;

    logic        clk = 1'b0, reset_n = 1'b0, card_sense = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = 4'hF;
    logic [15:0] pin_ref = 16'h0;
    logic        txn_complete = 1'b0, txn_failed = 1'b0;
    logic        card_insert, pin_enter, txn_select, txn_confirm;
    logic [1:0]  txn_type;
    logic        pin_error, result_ok, result_fail, busy;

    int checks = 0, failures = 0;
    int n_perr = 0, n_ok = 0, n_fail = 0, n_conf = 0;

    atm_panel_ctrl #(
        .PIN_DIGITS(PIN_DIGITS), .MAX_TRIES(MAX_TRIES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT), .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .card_sense(card_sense), .key_valid(key_valid),
        .key_code(key_code), .pin_ref(pin_ref), .txn_complete(txn_complete),
        .txn_failed(txn_failed), .card_insert(card_insert), .pin_enter(pin_enter),
        .txn_select(txn_select), .txn_confirm(txn_confirm), .txn_type(txn_type),
        .pin_error(pin_error), .result_ok(result_ok), .result_fail(result_fail),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (pin_error)   n_perr++;
        if (result_ok)   n_ok++;
        if (result_fail) n_fail++;
        if (txn_confirm) n_conf++;
    end

    function automatic logic [9:0] all_outs();
        return {card_insert, pin_enter, txn_select, txn_confirm, txn_type,
                pin_error, result_ok, result_fail, busy};
    endfunction

    function automatic logic [3:0] levels();
        return {card_insert, pin_enter, txn_select, busy};
    endfunction

    function automatic logic [15:0] rand_pin();
        logic [15:0] p = '0;
        for (int i = 0; i < PIN_DIGITS; i++) p = {p[11:0], 4'($urandom_range(0, 9))};
        return p;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; key_code = 4'hF;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = PIN_DIGITS - 1; i >= 0; i--) press(p[4*i +: 4]);
    endtask

    task automatic reach_select(input logic [15:0] p, input int t);
        pin_ref = p; card_sense = 1'b1; tick();
        enter_pin(p); press(4'hA); press(4'hC + 4'(t));
    endtask

    task automatic remove_card();
        card_sense = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; card_sense = 1'b0;
        tick(); tick();
        checks++; if (all_outs() !== 10'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", all_outs()); end
        reset_n = 1'b1; tick();
        checks++; if (all_outs() !== 10'b0) begin failures++; $display("FAIL reset_release got=%b exp=0", all_outs()); end
    endtask

    // mode 0: complete, 1: failed, 2: both in same cycle (failure wins)
    task automatic test_happy(input int mode, input int delay);
        logic [15:0] p = rand_pin();
        int t = $urandom_range(0, 2);
        int b_ok = n_ok, b_fail = n_fail, b_conf = n_conf, b_perr = n_perr;
        pin_ref = p; card_sense = 1'b1; tick();
        checks++; if (levels() !== 4'b1001) begin failures++; $display("FAIL happy_card got=%b exp=1001", levels()); end
        enter_pin(p); press(4'hA);
        checks++; if (levels() !== 4'b1101) begin failures++; $display("FAIL happy_pin got=%b exp=1101", levels()); end
        press(4'hC + 4'(t));
        checks++; if (levels() !== 4'b1111 || txn_type !== 2'(t)) begin failures++; $display("FAIL happy_select got=%b/%0d exp=1111/%0d", levels(), txn_type, t); end
        press(4'hA);
        checks++; if (txn_confirm !== 1'b1 || levels() !== 4'b1111) begin failures++; $display("FAIL happy_confirm got=%b/%b exp=1/1111", txn_confirm, levels()); end
        tick();
        checks++; if (txn_confirm !== 1'b0 || levels() !== 4'b0001) begin failures++; $display("FAIL happy_wait got=%b/%b exp=0/0001", txn_confirm, levels()); end
        repeat (delay - 2) tick();
        txn_complete = (mode != 1); txn_failed = (mode != 0);
        tick();
        txn_complete = 1'b0; txn_failed = 1'b0;
        checks++; if (result_ok !== (mode == 0) || result_fail !== (mode != 0) || levels() !== 4'b0001) begin
            failures++; $display("FAIL happy_result mode=%0d got ok=%b fail=%b lv=%b", mode, result_ok, result_fail, levels()); end
        remove_card();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL happy_idle got=%b exp=0", busy); end
        checks++; if (n_ok - b_ok != (mode == 0 ? 1 : 0) || n_fail - b_fail != (mode == 0 ? 0 : 1) ||
                      n_conf - b_conf != 1 || n_perr != b_perr) begin
            failures++; $display("FAIL happy_counts ok=%0d fail=%0d conf=%0d perr=%0d mode=%0d",
                                 n_ok - b_ok, n_fail - b_fail, n_conf - b_conf, n_perr - b_perr, mode); end
    endtask

    task automatic test_wrong_pin();
        int b_perr = n_perr, b_fail = n_fail;
        logic [15:0] p;
        do p = rand_pin(); while (p == 16'h1111);
        pin_ref = p; card_sense = 1'b1; tick();
        for (int k = 0; k < MAX_TRIES; k++) begin
            enter_pin(16'h1111); press(4'hA);
            checks++; if (pin_error !== 1'b1 || pin_enter !== 1'b0 || result_fail !== (k == MAX_TRIES - 1) ||
                          card_insert !== (k != MAX_TRIES - 1)) begin
                failures++; $display("FAIL wrong_pin try=%0d got perr=%b pe=%b fail=%b ci=%b", k, pin_error, pin_enter, result_fail, card_insert); end
        end
        tick();
        checks++; if (busy !== 1'b1 || card_insert !== 1'b0 || n_perr - b_perr != 3 || n_fail - b_fail != 1) begin
            failures++; $display("FAIL wrong_pin_eject busy=%b ci=%b perr=%0d fail=%0d", busy, card_insert, n_perr - b_perr, n_fail - b_fail); end
        remove_card();
    endtask

    task automatic test_short_long();
        pin_ref = 16'h1234; card_sense = 1'b1; tick();
        press(4'h1); press(4'h2); press(4'h3); press(4'hA);
        checks++; if (pin_error !== 1'b1 || pin_enter !== 1'b0) begin failures++; $display("FAIL short_pin got perr=%b pe=%b exp=1/0", pin_error, pin_enter); end
        for (int d = 1; d <= 5; d++) press(4'(d));
        press(4'hA);
        checks++; if (pin_error !== 1'b0 || pin_enter !== 1'b1) begin failures++; $display("FAIL long_pin got perr=%b pe=%b exp=0/1", pin_error, pin_enter); end
        press(4'hB);
        checks++; if (result_fail !== 1'b1 || levels() !== 4'b0001) begin failures++; $display("FAIL cancel got fail=%b lv=%b exp=1/0001", result_fail, levels()); end
        remove_card();
    endtask

    task automatic test_pull_in_select();
        int b_conf = n_conf, b_fail = n_fail;
        reach_select(rand_pin(), $urandom_range(0, 2));
        key_code = 4'hA; key_valid = 1'b1; card_sense = 1'b0;
        tick();
        key_valid = 1'b0;
        checks++; if (txn_confirm !== 1'b0 || levels() !== 4'b0000 || result_fail !== 1'b1) begin
            failures++; $display("FAIL pull_select got conf=%b lv=%b fail=%b exp=0/0000/1", txn_confirm, levels(), result_fail); end
        tick();
        checks++; if (n_conf != b_conf || n_fail - b_fail != 1) begin failures++; $display("FAIL pull_counts conf=%0d fail=%0d exp=0/1", n_conf - b_conf, n_fail - b_fail); end
    endtask

    task automatic test_idle_timeout();
        pin_ref = rand_pin(); card_sense = 1'b1; tick();
        enter_pin(pin_ref); press(4'hA);
        repeat (IDLE_TIMEOUT - 1) tick();
        checks++; if (result_fail !== 1'b0 || pin_enter !== 1'b1) begin failures++; $display("FAIL idle_early got fail=%b pe=%b exp=0/1", result_fail, pin_enter); end
        tick();
        checks++; if (result_fail !== 1'b1 || levels() !== 4'b0001) begin failures++; $display("FAIL idle_expire got fail=%b lv=%b exp=1/0001", result_fail, levels()); end
        remove_card();
    endtask

    task automatic test_resp_timeout();
        reach_select(rand_pin(), $urandom_range(0, 2));
        press(4'hA);
        repeat (RESP_TIMEOUT - 1) tick();
        checks++; if (result_fail !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL resp_early got fail=%b busy=%b exp=0/1", result_fail, busy); end
        tick();
        checks++; if (result_fail !== 1'b1 || result_ok !== 1'b0) begin failures++; $display("FAIL resp_expire got fail=%b ok=%b exp=1/0", result_fail, result_ok); end
        remove_card();
    endtask

    task automatic test_reset_wait();
        reach_select(rand_pin(), $urandom_range(0, 2));
        press(4'hA);
        checks++; if (txn_confirm !== 1'b1) begin failures++; $display("FAIL rst_pre got conf=%b exp=1", txn_confirm); end
        #2; reset_n = 1'b0; card_sense = 1'b0; #1;
        checks++; if (all_outs() !== 10'b0) begin failures++; $display("FAIL rst_async got=%b exp=0", all_outs()); end
        tick();
        reset_n = 1'b1; tick();
        test_happy(0, 3);
    endtask

    // Random digit/ignored-key sequences against a queue model of PIN entry.
    task automatic test_random_pins();
        for (int s = 0; s < 6; s++) begin
            int tries = 0;
            bit done = 0;
            pin_ref = rand_pin(); card_sense = 1'b1; tick();
            while (!done) begin
                logic [3:0] q[$];
                logic [15:0] v = '0;
                int n;
                bit good = ($urandom_range(0, 2) == 0);
                n = good ? PIN_DIGITS + $urandom_range(0, 2) : $urandom_range(0, 6);
                for (int i = 0; i < n; i++) begin
                    logic [3:0] d = (good && i < PIN_DIGITS) ? pin_ref[4*(PIN_DIGITS-1-i) +: 4]
                                                             : 4'($urandom_range(0, 9));
                    if ($urandom_range(0, 3) == 0) press(4'($urandom_range(12, 15)));
                    press(d);
                    if (q.size() < PIN_DIGITS) q.push_back(d);
                end
                foreach (q[i]) v = {v[11:0], q[i]};
                press(4'hA);
                if (q.size() == PIN_DIGITS && v == pin_ref) begin
                    checks++; if (pin_enter !== 1'b1 || pin_error !== 1'b0) begin failures++; $display("FAIL rnd_accept s=%0d got pe=%b perr=%b exp=1/0", s, pin_enter, pin_error); end
                    press(4'hB);
                    checks++; if (result_fail !== 1'b1) begin failures++; $display("FAIL rnd_cancel s=%0d got=%b exp=1", s, result_fail); end
                    done = 1;
                end else begin
                    tries++;
                    checks++; if (pin_error !== 1'b1 || result_fail !== (tries == MAX_TRIES) ||
                                  card_insert !== (tries < MAX_TRIES)) begin
                        failures++; $display("FAIL rnd_reject s=%0d try=%0d got perr=%b fail=%b ci=%b", s, tries, pin_error, result_fail, card_insert); end
                    if (tries == MAX_TRIES) done = 1;
                end
            end
            card_sense = 1'b0; tick();
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle s=%0d got=%b exp=0", s, busy); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_happy(0, 3);
        test_happy(1, $urandom_range(2, 8));
        test_happy(2, $urandom_range(2, 8));
        test_wrong_pin();
        test_short_long();
        test_pull_in_select();
        test_idle_timeout();
        test_resp_timeout();
        test_reset_wait();
        test_random_pins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
